// File: rtl/xbus_pkg.sv
// xbus_pkg: shared register map limits, test-mode keys and FSM encodings
package xbus_pkg;
  localparam int MAX_NOR_REG_ADDR  = 8'h64;
  localparam int MAX_TEST_REG_ADDR = 8'h65;
  localparam int XBUS_ADDR_WIDTH   = 7;
  localparam logic [7:0] KEY_UNLOCK1 = 8'h5A;
  localparam logic [7:0] KEY_UNLOCK2 = 8'hA5;
  localparam logic [7:0] KEY_LOCK    = 8'h00;
  localparam logic [1:0] LD_REQ  = 2'd0;
  localparam logic [1:0] LD_WAIT = 2'd1;
  localparam logic [1:0] LD_GAP  = 2'd2;
  localparam logic [1:0] LD_DONE = 2'd3;
  localparam logic [1:0] TM_OFF  = 2'd0;
  localparam logic [1:0] TM_KEY1 = 2'd1;
  localparam logic [1:0] TM_ON   = 2'd2;
endpackage

// File: rtl/otp_loader.sv
// otp_loader: shadows OTP words 0..OTP_WORDS-1 into the register array after reset
module otp_loader #(
  parameter int AW          = 7,
  parameter int OTP_WORDS   = 8,
  parameter int OTP_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          otp_rd_req,
  output logic [AW-1:0] otp_rd_addr,
  input  logic          otp_rd_ack,
  input  logic [7:0]    otp_rd_data,
  output logic          otp_done,
  output logic          otp_err,
  output logic          ld_we,
  output logic [AW-1:0] ld_addr,
  output logic [7:0]    ld_data
);
  import xbus_pkg::*;
  localparam int CW = $clog2(OTP_TIMEOUT + 1);
  logic [1:0]    state;
  logic [AW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          expire, last;
  assign expire   = cnt == CW'(OTP_TIMEOUT - 1);
  assign last     = idx == AW'(OTP_WORDS - 1);
  assign ld_we    = state == LD_WAIT && (otp_rd_ack || expire);
  assign ld_addr  = idx;
  assign ld_data  = otp_rd_ack ? otp_rd_data : 8'h00;
  assign otp_done = state == LD_DONE;
  // GAP re-raises req so the low gap between requests is exactly one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= LD_REQ;
      idx         <= '0;
      cnt         <= '0;
      otp_rd_req  <= 1'b0;
      otp_rd_addr <= '0;
      otp_err     <= 1'b0;
    end else if (state == LD_REQ) begin
      otp_rd_req  <= 1'b1;
      otp_rd_addr <= idx;
      state       <= LD_WAIT;
    end else if (state == LD_WAIT) begin
      cnt <= ld_we ? '0 : cnt + 1'b1;
      if (ld_we) begin
        otp_rd_req <= 1'b0;
        otp_err    <= otp_err | ~otp_rd_ack;
        state      <= last ? LD_DONE : LD_GAP;
      end
    end else if (state == LD_GAP) begin
      idx         <= idx + 1'b1;
      otp_rd_addr <= idx + 1'b1;
      otp_rd_req  <= 1'b1;
      state       <= LD_REQ;
    end
endmodule

// File: rtl/xbus_regfile.sv
// xbus_regfile: hif-writable register array with OTP shadow load and test-mode unlock
module xbus_regfile #(
  parameter int MAX_NOR_REG_ADDR  = xbus_pkg::MAX_NOR_REG_ADDR,
  parameter int MAX_TEST_REG_ADDR = xbus_pkg::MAX_TEST_REG_ADDR,
  parameter int XBUS_ADDR_WIDTH   = xbus_pkg::XBUS_ADDR_WIDTH,
  parameter int OTP_WORDS         = 8,
  parameter int OTP_TIMEOUT       = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [XBUS_ADDR_WIDTH-1:0]       xbus_addr,
  input  logic                             xbus_wr,
  input  logic [7:0]                       xbus_din,
  output logic [7:0]                       xbus_dout,
  output logic                             otp_rd_req,
  output logic [XBUS_ADDR_WIDTH-1:0]       otp_rd_addr,
  input  logic                             otp_rd_ack,
  input  logic [7:0]                       otp_rd_data,
  output logic                             otp_done,
  output logic                             otp_err,
  output logic                             testmode_en,
  output logic [8*(MAX_NOR_REG_ADDR+1)-1:0] cfg_regs
);
  import xbus_pkg::*;
  localparam logic [7:0] NOR = 8'(MAX_NOR_REG_ADDR);
  localparam logic [7:0] TST = 8'(MAX_TEST_REG_ADDR);
  logic [7:0]                 regs [0:MAX_NOR_REG_ADDR];
  logic [2:0]                 sync;
  logic [1:0]                 tm_state, tm_next;
  logic [7:0]                 a;
  logic                       wr_stb, acc, wr_en, tst;
  logic                       ld_we;
  logic [XBUS_ADDR_WIDTH-1:0] ld_addr;
  logic [7:0]                 ld_data;
  otp_loader #(.AW(XBUS_ADDR_WIDTH), .OTP_WORDS(OTP_WORDS), .OTP_TIMEOUT(OTP_TIMEOUT)) u_ld (
    .clk(clk), .rst_n(rst_n), .otp_rd_req(otp_rd_req), .otp_rd_addr(otp_rd_addr),
    .otp_rd_ack(otp_rd_ack), .otp_rd_data(otp_rd_data), .otp_done(otp_done),
    .otp_err(otp_err), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );
  // sync[2] is the previous synchronised level, so the write lands on the 3rd edge
  assign wr_stb = sync[1] & ~sync[2];
  assign a      = 8'(xbus_addr);
  assign acc    = wr_stb & otp_done;
  assign tst    = a == TST;
  assign wr_en  = acc && a <= NOR;
  assign tm_next = !acc ? tm_state :
                   tm_state == TM_OFF  ? (tst && xbus_din == KEY_UNLOCK1 ? TM_KEY1 : TM_OFF) :
                   tm_state == TM_KEY1 ? (tst && xbus_din == KEY_UNLOCK2 ? TM_ON : TM_OFF) :
                   (tst && xbus_din == KEY_LOCK ? TM_OFF : TM_ON);
  assign testmode_en = tm_state == TM_ON;
  assign xbus_dout = a <= NOR ? regs[xbus_addr] :
                     tst ? {6'b0, tm_state == TM_KEY1, testmode_en} : 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync     <= '0;
      tm_state <= TM_OFF;
    end else begin
      sync     <= {sync[1:0], xbus_wr};
      tm_state <= tm_next;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i <= MAX_NOR_REG_ADDR; i++) regs[i] <= 8'h00;
    else
      for (int i = 0; i <= MAX_NOR_REG_ADDR; i++)
        if (ld_we && 8'(ld_addr) == 8'(i)) regs[i] <= ld_data;
        else if (wr_en && a == 8'(i)) regs[i] <= xbus_din;
  for (genvar r = 0; r <= MAX_NOR_REG_ADDR; r++) begin : g_cfg
    assign cfg_regs[8*r +: 8] = regs[r];
  end
endmodule

// File: tb/tb_xbus_regfile.sv
// tb_xbus_regfile: directed scenarios with an OTP responder feeding an expected-value queue
module tb_xbus_regfile;
  typedef struct { int a; logic [7:0] d; } exp_t;
  logic       clk = 0, rst_n = 0, xbus_wr = 0, otp_rd_ack = 0;
  logic [6:0] xbus_addr = 0, otp_rd_addr;
  logic [7:0] xbus_din = 0, xbus_dout, otp_rd_data = 0;
  logic       otp_rd_req, otp_done, otp_err, testmode_en;
  logic [807:0] cfg_regs, snap;
  exp_t sbq[$];
  int n_vec = 0, n_err = 0, skip_word = -1, pulses = 0, low = 0, gap_bad = 0;

  xbus_regfile dut (
    .clk(clk), .rst_n(rst_n), .xbus_addr(xbus_addr), .xbus_wr(xbus_wr), .xbus_din(xbus_din),
    .xbus_dout(xbus_dout), .otp_rd_req(otp_rd_req), .otp_rd_addr(otp_rd_addr),
    .otp_rd_ack(otp_rd_ack), .otp_rd_data(otp_rd_data), .otp_done(otp_done),
    .otp_err(otp_err), .testmode_en(testmode_en), .cfg_regs(cfg_regs)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(int n);
    return cfg_regs[8*n +: 8];
  endfunction

  // OTP model: acks on the 3rd sampled cycle of each request unless the word is skipped
  initial begin
    int k = 0;
    forever begin
      @(negedge clk);
      otp_rd_ack = 0;
      if (!rst_n || !otp_rd_req) k = 0;
      else begin
        k++;
        if (k == 3 && int'(otp_rd_addr) != skip_word) begin
          otp_rd_ack  = 1;
          otp_rd_data = 8'h10 + 8'(otp_rd_addr);
          sbq.push_back('{int'(otp_rd_addr), 8'h10 + 8'(otp_rd_addr)});
        end
      end
    end
  end

  initial begin
    logic prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pulses = 0; low = 0; gap_bad = 0; prev = 0; end
      else begin
        if (otp_rd_req && !prev) begin
          if (pulses > 0 && low != 1) gap_bad++;
          pulses++;
        end
        low  = otp_rd_req ? 0 : low + 1;
        prev = otp_rd_req;
      end
    end
  end

  task automatic do_reset(int skip);
    @(negedge clk);
    rst_n = 0;
    skip_word = skip;
    sbq.delete();
    if (skip >= 0) sbq.push_back('{skip, 8'h00});
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic wait_done(int lim);
    int n = 0;
    while (!otp_done && n < lim) begin @(negedge clk); n++; end
    check("otp_done", otp_done, 1);
  endtask

  task automatic drain(string tag);
    check({tag, "_sb_size"}, sbq.size(), 8);
    while (sbq.size() > 0) begin
      exp_t e = sbq.pop_front();
      check($sformatf("%s_reg%0d", tag, e.a), reg_at(e.a), e.d);
    end
  endtask

  task automatic xwrite(logic [6:0] ad, logic [7:0] d);
    @(negedge clk);
    xbus_addr = ad; xbus_din = d; xbus_wr = 1;
    repeat (6) @(negedge clk);
    xbus_wr = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic rd(string tag, logic [6:0] ad, logic [7:0] exp);
    xbus_addr = ad;
    #1 check(tag, xbus_dout, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", otp_rd_req, 0);
    check("rst_done", otp_done, 0);
    check("rst_err", otp_err, 0);
    check("rst_tm", testmode_en, 0);
    check("rst_regs", |cfg_regs, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("first_req", otp_rd_req, 1);
    check("first_addr", otp_rd_addr, 0);
    xwrite(7'h20, 8'h5C);
    check("gated_write", reg_at(8'h20), 8'h00);
    wait_done(2000);
    check("boot_err", otp_err, 0);
    check("boot_pulses", pulses, 8);
    check("boot_gaps", gap_bad, 0);
    drain("boot");
    // timed write: lands on 3rd edge, and only once per wr high period
    @(negedge clk);
    xbus_addr = 7'h20; xbus_din = 8'h5C; xbus_wr = 1;
    repeat (2) @(posedge clk);
    #1 check("wr_edge2", reg_at(8'h20), 8'h00);
    @(posedge clk);
    #1 check("wr_edge3", reg_at(8'h20), 8'h5C);
    repeat (2) @(negedge clk);
    xbus_din = 8'h77;
    repeat (4) @(negedge clk);
    xbus_wr = 0;
    repeat (4) @(negedge clk);
    check("wr_once", reg_at(8'h20), 8'h5C);
    xwrite(7'h65, 8'h5A);
    rd("tm_key1_rd", 7'h65, 8'h02);
    xwrite(7'h65, 8'hA5);
    check("tm_on", testmode_en, 1);
    rd("tm_on_rd", 7'h65, 8'h01);
    xwrite(7'h65, 8'h12);
    check("tm_on_hold", testmode_en, 1);
    xwrite(7'h65, 8'h00);
    check("tm_lock", testmode_en, 0);
    xwrite(7'h65, 8'h5A);
    xwrite(7'h10, 8'h33);
    xwrite(7'h65, 8'hA5);
    check("tm_broken", testmode_en, 0);
    check("tm_reg10", reg_at(8'h10), 8'h33);
    rd("tm_off_rd", 7'h65, 8'h00);
    snap = cfg_regs;
    xwrite(7'h66, 8'h11);
    xwrite(7'h7F, 8'h22);
    check("dec_nochange", cfg_regs == snap, 1);
    rd("dec_rd66", 7'h66, 8'h00);
    rd("dec_rd7f", 7'h7F, 8'h00);
    xwrite(7'h64, 8'h9C);
    rd("dec_rd64", 7'h64, 8'h9C);
    do_reset(3);
    wait_done(3000);
    check("to_err", otp_err, 1);
    check("to_pulses", pulses, 8);
    drain("to");
    do_reset(-1);
    begin
      int n = 0;
      while (n < 300) begin
        @(negedge clk); #1;
        if (otp_rd_ack && otp_rd_addr == 7'd4) break;
        n++;
      end
      check("mid_found", n < 300, 1);
    end
    rst_n = 0;
    sbq.delete();
    #1;
    check("mid_req", otp_rd_req, 0);
    check("mid_addr", otp_rd_addr, 0);
    check("mid_done", otp_done, 0);
    check("mid_err", otp_err, 0);
    check("mid_regs", |cfg_regs, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    check("mid_req1", otp_rd_req, 1);
    check("mid_addr1", otp_rd_addr, 0);
    wait_done(2000);
    drain("mid");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
